// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl
// Description : MEM-stage controller. Converts the EX/MEM memory controls into
//               a single req/ack transaction on a multi-cycle data memory,
//               stalls the upstream pipeline while the access is in flight
//               and presents load data to the MEM/WB register.
//               Optional feature macro: MEM_BYTE_LOAD_EN (zero-extended byte
//               loads selected by address bit 0).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_mem_read,
    input  logic              m_mem_write,
    input  logic              m_load_byte,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_stall,
    output logic [DATA_W-1:0] w_rdata,
    output logic              w_rdata_valid,
    output logic              mem_err
);

    // Counter must be able to represent MAX_WAIT itself.
    localparam int c_CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_acc;
    logic                w_stall;
    logic                w_timeout;
    logic [DATA_W-1:0]   w_load_val;
    logic                r_req;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_valid;
    logic                r_err;
    logic [c_CNT_W-1:0]  r_cnt;

    // Any memory operation in EX/MEM needs a transaction; read+write counts as a write.
    assign w_acc = m_mem_read | m_mem_write;

`ifdef MEM_BYTE_LOAD_EN
    logic r_lb;

    // Byte-load flag captured with the rest of the access so later EX/MEM changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lb <= 1'b0;
        end else if (r_state == ST_IDLE && w_acc) begin
            r_lb <= m_load_byte & m_mem_read & ~m_mem_write;
        end
    end

    // Select the addressed byte and zero-extend it for byte loads.
    always_comb begin
        w_load_val = mem_rdata;
        if (r_lb) begin
            if (r_addr[0]) begin
                w_load_val = {{(DATA_W-8){1'b0}}, mem_rdata[15:8]};
            end else begin
                w_load_val = {{(DATA_W-8){1'b0}}, mem_rdata[7:0]};
            end
        end
    end
`else
    // Byte loads are not supported in this build; the flag is deliberately dropped.
    logic w_unused_load_byte;
    assign w_unused_load_byte = m_load_byte;
    assign w_load_val         = mem_rdata;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the combinational stall; an ack beats a same-cycle timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stall = w_acc;
                if (w_acc) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_stall = 1'b1;
                if (mem_ack) begin
                    w_state_nxt = ST_DONE;
                end else if (r_cnt == c_CNT_W'(MAX_WAIT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch address, store data and direction when an access is accepted in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
        end else if (r_state == ST_IDLE && w_acc) begin
            r_addr  <= m_addr;
            r_wdata <= m_wdata;
            r_we    <= m_mem_write;
        end
    end

    // Request is high for exactly the BUSY cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req <= 1'b0;
        end else if (w_state_nxt == ST_BUSY) begin
            r_req <= 1'b1;
        end else begin
            r_req <= 1'b0;
        end
    end

    // Wait counter runs only while BUSY and clears everywhere else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_BUSY) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Completion: capture read data on ack, force zero on timeout; valid marks the DONE cycle of a read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
            r_valid <= 1'b0;
        end else if (r_state == ST_BUSY && mem_ack) begin
            if (!r_we) begin
                r_rdata <= w_load_val;
            end
            r_valid <= ~r_we;
        end else if (w_timeout) begin
            r_rdata <= '0;
            r_valid <= ~r_we;
        end else begin
            r_valid <= 1'b0;
        end
    end

    // Timeout flag is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign mem_req       = r_req;
    assign mem_we        = r_we;
    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;
    assign mem_stall     = w_stall & ~rst;
    assign w_rdata       = r_rdata;
    assign w_rdata_valid = r_valid;
    assign mem_err       = r_err;

endmodule
`default_nettype wire
